// File: rtl/ag32gbd_pkg.sv
// Shared widths, init constants and FSM encoding for the camera register responder.
// Pure definitions: no latency, no flow control.
package ag32gbd_pkg;

  localparam int ADDR_W = 10;
  localparam int VAL_W  = 8;
  localparam int DATA_W = VAL_W + 1;
  localparam int K_W    = 6;

  localparam logic [ADDR_W-1:0] INIT_BASE  = 10'h200;
  localparam int                INIT_COUNT = 48;

  localparam logic [VAL_W-1:0] DEF_LOW  = 8'h40;
  localparam logic [VAL_W-1:0] DEF_MID  = 8'h80;
  localparam logic [VAL_W-1:0] DEF_HIGH = 8'hC0;

  // One-hot; READY means RegReadOutput holds valid data for the captured address.
  typedef enum logic [2:0] {
    S_INIT  = 3'b001,
    S_IDLE  = 3'b010,
    S_READY = 3'b100
  } state_t;

  // phase is the init index k mod 3, tracked as a wrapping counter.
  function automatic logic [VAL_W-1:0] def_threshold(input logic [1:0] phase);
    logic [VAL_W-1:0] v;
    case (phase)
      2'd0:    v = DEF_LOW;
      2'd1:    v = DEF_MID;
      default: v = DEF_HIGH;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ag32gbd_reg_ram.sv
// 1024x9 simple dual-port RAM, one write port and one registered read port.
// Read data appears one cycle after re; contents and read register are never reset.
module ag32gbd_reg_ram
  import ag32gbd_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Read-before-write on a same-address collision; the responder re-reads in that case.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ag32gbd_reg_responder.sv
// Register/threshold RAM responder: loads defaults for 48 cycles, then serves reads in 2 cycles
// after the last request-high cycle; host writes are accepted every cycle outside init.
module ag32gbd_reg_responder
  import ag32gbd_pkg::*;
(
  input  logic              sys_clock,
  input  logic              sys_reset,
  input  logic              RequestReadReg,
  input  logic [ADDR_W-1:0] RegReadAddr,
  output logic [DATA_W-1:0] RegReadOutput,
  output logic              RegReadDataReady,
  input  logic              WriteReq,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [VAL_W-1:0]  WriteData,
  output logic              WriteAccept,
  output logic              InitBusy
);

  state_t            state, state_nxt;
  logic [K_W-1:0]    k, k_nxt;
  logic [1:0]        phase, phase_nxt;
  logic [ADDR_W-1:0] cap_addr, cap_addr_nxt;
  logic              pending, pending_nxt;

  logic              host_wr;
  logic              collide;
  logic              issue_rd;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      k        <= '0;
      phase    <= '0;
      cap_addr <= '0;
      pending  <= 1'b0;
    end else begin
      k        <= k_nxt;
      phase    <= phase_nxt;
      cap_addr <= cap_addr_nxt;
      pending  <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    k_nxt        = k;
    phase_nxt    = phase;
    cap_addr_nxt = cap_addr;
    pending_nxt  = pending;
    issue_rd     = 1'b0;
    ram_we       = 1'b0;
    ram_waddr    = WriteAddr;
    ram_wdata    = {1'b1, WriteData};

    host_wr = WriteReq && (state != S_INIT);
    // A write landing on the captured address invalidates whatever was or is about to be read.
    collide = host_wr && (WriteAddr == cap_addr) && (pending || (state == S_READY));

    unique case (state)
      S_INIT: begin
        ram_we    = 1'b1;
        ram_waddr = INIT_BASE + ADDR_W'(k);
        ram_wdata = {1'b0, def_threshold(phase)};
        k_nxt     = k + K_W'(1);
        phase_nxt = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        if (k == K_W'(INIT_COUNT - 1)) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        ram_we = host_wr;
        if (pending && !RequestReadReg && !collide) begin
          issue_rd    = 1'b1;
          pending_nxt = 1'b0;
          state_nxt   = S_READY;
        end
      end
      S_READY: begin
        ram_we = host_wr;
        if (collide) begin
          pending_nxt = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      default: state_nxt = S_INIT;
    endcase

    // Capture is unconditional: the last request-high cycle always defines the address.
    if (RequestReadReg) begin
      cap_addr_nxt = RegReadAddr;
      pending_nxt  = 1'b1;
      if (state == S_READY) state_nxt = S_IDLE;
    end
  end

  ag32gbd_reg_ram u_ram (
    .clk   (sys_clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (issue_rd),
    .raddr (cap_addr),
    .rdata (ram_rdata)
  );

  assign InitBusy         = (state == S_INIT);
  assign WriteAccept      = !InitBusy;
  assign RegReadDataReady = (state == S_READY);
  // The RAM read register holds between reads; masking keeps the output at zero out of reset.
  assign RegReadOutput    = RegReadDataReady ? ram_rdata : '0;

endmodule
